// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/func constants, FSM states, select encodings and control bundle
package mips_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_e;
   localparam logic [1:0] PC_PLUS4 = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_REG = 2'd3;
   localparam logic [1:0] WA_RD = 2'd0, WA_RT = 2'd1, WA_RA = 2'd2;
   localparam logic [1:0] WD_PC4 = 2'd0, WD_ALU = 2'd1, WD_MEM = 2'd2;
   // A_C16 feeds a constant 16 as shift amount so LUI is imm << 16
   localparam logic [1:0] A_RS = 2'd0, A_SHAMT = 2'd1, A_C16 = 2'd2;
   localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3, ALU_XOR = 5'd4;
   localparam logic [4:0] ALU_NOR = 5'd5, ALU_SLT = 5'd6, ALU_SLTU = 5'd7, ALU_SLL = 5'd8, ALU_SRL = 5'd9;
   localparam logic [4:0] ALU_SRA = 5'd10;
   typedef enum logic [3:0] {C_ALU, C_BEQ, C_BNE, C_J, C_JR, C_JAL, C_JALR, C_LW, C_SW} cls_e;
   typedef struct packed {
      cls_e       cls;
      logic [1:0] wasel;
      logic [1:0] wdsel;
      logic [1:0] asel;
      logic       bsel;
      logic       sgnext;
      logic [4:0] alufn;
   } ctl_t;
endpackage

// File: rtl/mips_decode.sv
// mips_decode: combinational op/func to control bundle plus illegal flag
module mips_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output ctl_t       ctl,
   output logic       illegal
);
   always_comb begin
      ctl = '{cls: C_ALU, wasel: WA_RT, wdsel: WD_ALU, asel: A_RS, bsel: 1'b1, sgnext: 1'b1, alufn: ALU_ADD};
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            ctl.wasel = WA_RD;
            ctl.bsel = 1'b0;
            case (func)
               FN_SLL: begin ctl.asel = A_SHAMT; ctl.alufn = ALU_SLL; end
               FN_SRL: begin ctl.asel = A_SHAMT; ctl.alufn = ALU_SRL; end
               FN_SRA: begin ctl.asel = A_SHAMT; ctl.alufn = ALU_SRA; end
               FN_SLLV: ctl.alufn = ALU_SLL;
               FN_SRLV: ctl.alufn = ALU_SRL;
               FN_SRAV: ctl.alufn = ALU_SRA;
               FN_JR: ctl.cls = C_JR;
               FN_JALR: begin ctl.cls = C_JALR; ctl.wdsel = WD_PC4; end
               FN_ADD, FN_ADDU: ctl.alufn = ALU_ADD;
               FN_SUB, FN_SUBU: ctl.alufn = ALU_SUB;
               FN_AND: ctl.alufn = ALU_AND;
               FN_OR: ctl.alufn = ALU_OR;
               FN_XOR: ctl.alufn = ALU_XOR;
               FN_NOR: ctl.alufn = ALU_NOR;
               FN_SLT: ctl.alufn = ALU_SLT;
               FN_SLTU: ctl.alufn = ALU_SLTU;
               default: illegal = 1'b1;
            endcase
         end
         OP_J: ctl.cls = C_J;
         OP_JAL: begin ctl.cls = C_JAL; ctl.wasel = WA_RA; ctl.wdsel = WD_PC4; end
         OP_BEQ: begin ctl.cls = C_BEQ; ctl.bsel = 1'b0; ctl.alufn = ALU_SUB; end
         OP_BNE: begin ctl.cls = C_BNE; ctl.bsel = 1'b0; ctl.alufn = ALU_SUB; end
         OP_ADDI, OP_ADDIU: ctl.alufn = ALU_ADD;
         OP_SLTI: ctl.alufn = ALU_SLT;
         OP_SLTIU: ctl.alufn = ALU_SLTU;
         OP_ANDI: begin ctl.sgnext = 1'b0; ctl.alufn = ALU_AND; end
         OP_ORI: begin ctl.sgnext = 1'b0; ctl.alufn = ALU_OR; end
         OP_XORI: begin ctl.sgnext = 1'b0; ctl.alufn = ALU_XOR; end
         OP_LUI: begin ctl.sgnext = 1'b0; ctl.asel = A_C16; ctl.alufn = ALU_SLL; end
         OP_LW: begin ctl.cls = C_LW; ctl.wdsel = WD_MEM; end
         OP_SW: ctl.cls = C_SW;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with ready timeouts.
// Define MC_PERF_COUNTERS_EN to build the cycle/retire performance counters.
module mips_multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int ALUFN_W  = 5,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic [5:0]         op,
   input  logic [5:0]         func,
   input  logic               Z,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               ir_we,
   output logic               pc_we,
   output logic [1:0]         pcsel,
   output logic [1:0]         wasel,
   output logic               sgnext,
   output logic               bsel,
   output logic [1:0]         wdsel,
   output logic [ALUFN_W-1:0] alufn,
   output logic [1:0]         asel,
   output logic               wr,
   output logic               werf,
   output logic               instr_done,
   output logic               illegal,
   output logic               bus_err,
   output logic [2:0]         state,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   retire_cnt
);
   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   state_e        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   ctl_t          ctl;
   logic          dec_ill, rdy, waiting, tmo, en;
   mips_decode u_dec (.op(op), .func(func), .ctl(ctl), .illegal(dec_ill));
   assign wasel  = ctl.wasel;
   assign wdsel  = ctl.wdsel;
   assign asel   = ctl.asel;
   assign bsel   = ctl.bsel;
   assign sgnext = ctl.sgnext;
   assign alufn  = ALUFN_W'(ctl.alufn);
   assign state  = state_q;
   // reset_n gates strobes too, so a reset landing mid-instruction commits nothing
   assign en      = enable & reset_n;
   assign rdy     = (state_q == FETCH) ? imem_ready : dmem_ready;
   assign waiting = (state_q == FETCH || state_q == MEM) && !rdy;
   assign tmo     = (MAX_WAIT != 0) && enable && waiting && wait_q == WW'(MAX_WAIT - 1);
   assign wait_d  = (state_d != state_q || tmo) ? '0 : wait_q + WW'(waiting);
   always_ff @(posedge clk)
      if (!reset_n) begin
         state_q <= FETCH;
         wait_q  <= '0;
      end else if (enable) begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   always_comb begin
      state_d = state_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_we = 1'b0;
      pc_we = 1'b0;
      pcsel = PC_PLUS4;
      wr = 1'b0;
      werf = 1'b0;
      instr_done = 1'b0;
      illegal = 1'b0;
      bus_err = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = !tmo;
            ir_we = imem_ready;
            bus_err = tmo;
            state_d = imem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            illegal = dec_ill;
            pc_we = dec_ill;
            state_d = dec_ill ? FETCH : EXEC;
         end
         EXEC: begin
            pc_we = ctl.cls inside {C_BEQ, C_BNE, C_J, C_JR};
            instr_done = ctl.cls inside {C_BEQ, C_BNE, C_J, C_JR};
            pcsel = ctl.cls == C_J ? PC_JMP : ctl.cls == C_JR ? PC_REG :
                    ((ctl.cls == C_BEQ && Z) || (ctl.cls == C_BNE && !Z)) ? PC_BR : PC_PLUS4;
            state_d = (ctl.cls inside {C_BEQ, C_BNE, C_J, C_JR}) ? FETCH :
                      (ctl.cls inside {C_LW, C_SW}) ? MEM : WB;
         end
         MEM: begin
            dmem_req = !tmo;
            wr = ctl.cls == C_SW && !tmo;
            bus_err = tmo;
            pc_we = tmo || (dmem_ready && ctl.cls == C_SW);
            instr_done = dmem_ready && ctl.cls == C_SW;
            state_d = tmo ? FETCH : !dmem_ready ? MEM : ctl.cls == C_SW ? FETCH : WB;
         end
         WB: begin
            pc_we = 1'b1;
            werf = 1'b1;
            instr_done = 1'b1;
            pcsel = ctl.cls == C_JAL ? PC_JMP : ctl.cls == C_JALR ? PC_REG : PC_PLUS4;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      if (!en) {ir_we, pc_we, wr, werf, instr_done, illegal, bus_err} = '0;
   end
`ifdef MC_PERF_COUNTERS_EN
   logic [CNT_W-1:0] cyc_q, ret_q;
   always_ff @(posedge clk)
      if (!reset_n) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (enable) cyc_q <= cyc_q + CNT_W'(1);
         if (instr_done) ret_q <= ret_q + CNT_W'(1);
      end
   assign cycle_cnt  = cyc_q;
   assign retire_cnt = ret_q;
`else
   assign cycle_cnt  = '0;
   assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed per-cycle vectors for the multicycle controller.
module tb_mips_multicycle_controller;
   logic clk = 1'b0, reset_n = 1'b0, enable = 1'b1, Z = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic [5:0] op = '0, func = '0;
   logic imem_req, dmem_req, ir_we, pc_we, sgnext, bsel, wr, werf, instr_done, illegal, bus_err;
   logic [1:0] pcsel, wasel, wdsel, asel;
   logic [4:0] alufn;
   logic [2:0] state;
   logic [31:0] cycle_cnt, retire_cnt;
   logic [13:0] obs;
   logic [12:0] sel;
   int n_vec = 0, n_err = 0, ncyc = 0, nret = 0;
   mips_multicycle_controller dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .op(op), .func(func), .Z(Z),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
      .ir_we(ir_we), .pc_we(pc_we), .pcsel(pcsel), .wasel(wasel), .sgnext(sgnext), .bsel(bsel),
      .wdsel(wdsel), .alufn(alufn), .asel(asel), .wr(wr), .werf(werf), .instr_done(instr_done),
      .illegal(illegal), .bus_err(bus_err), .state(state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );
   always #5 clk = ~clk;
   // state_imemreq_dmemreq_irwe_pcwe_pcsel_wr_werf_done_illegal_buserr
   assign obs = {state, imem_req, dmem_req, ir_we, pc_we, pcsel, wr, werf, instr_done, illegal, bus_err};
   assign sel = {wasel, wdsel, asel, bsel, sgnext, alufn};
   localparam logic [13:0] FW  = 14'b000_1_0_0_0_00_0_0_0_0_0;
   localparam logic [13:0] FH  = 14'b000_1_0_1_0_00_0_0_0_0_0;
   localparam logic [13:0] FTO = 14'b000_0_0_0_0_00_0_0_0_0_1;
   localparam logic [13:0] DEC = 14'b001_0_0_0_0_00_0_0_0_0_0;
   localparam logic [13:0] ILL = 14'b001_0_0_0_1_00_0_0_0_1_0;
   localparam logic [13:0] EXQ = 14'b010_0_0_0_0_00_0_0_0_0_0;
   localparam logic [13:0] BRT = 14'b010_0_0_0_1_01_0_0_1_0_0;
   localparam logic [13:0] BRN = 14'b010_0_0_0_1_00_0_0_1_0_0;
   localparam logic [13:0] JMP = 14'b010_0_0_0_1_10_0_0_1_0_0;
   localparam logic [13:0] JRG = 14'b010_0_0_0_1_11_0_0_1_0_0;
   localparam logic [13:0] MRD = 14'b011_0_1_0_0_00_0_0_0_0_0;
   localparam logic [13:0] MSW = 14'b011_0_1_0_0_00_1_0_0_0_0;
   localparam logic [13:0] MSD = 14'b011_0_1_0_1_00_1_0_1_0_0;
   localparam logic [13:0] MTO = 14'b011_0_0_0_1_00_0_0_0_0_1;
   localparam logic [13:0] WB0 = 14'b100_0_0_0_1_00_0_1_1_0_0;
   localparam logic [13:0] WBJ = 14'b100_0_0_0_1_10_0_1_1_0_0;
   localparam logic [13:0] WBR = 14'b100_0_0_0_1_11_0_1_1_0_0;
   localparam logic [13:0] WBX = 14'b100_0_0_0_0_00_0_0_0_0_0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   // one clock cycle: drive readies, check mid-cycle, then track the enabled/retired count
   task automatic vec(input string tag, input logic ir, input logic dr, input logic [13:0] exp);
      imem_ready = ir;
      dmem_ready = dr;
      #4;
      check(tag, 32'(obs), 32'(exp));
      @(posedge clk);
      if (!reset_n) begin
         ncyc = 0;
         nret = 0;
      end else begin
         if (enable) ncyc++;
         if (exp[2]) nret++;
      end
      #1;
   endtask
   task automatic dsel(input string tag, input logic [12:0] mask, input logic [12:0] exp);
      #2;
      check({tag, " sel"}, 32'(sel & mask), 32'(exp & mask));
      vec({tag, " dec"}, 1'b0, 1'b0, DEC);
   endtask
   task automatic cnt_chk(input string tag);
`ifdef MC_PERF_COUNTERS_EN
      check({tag, " cycle_cnt"}, cycle_cnt, 32'(ncyc));
      check({tag, " retire_cnt"}, retire_cnt, 32'(nret));
`else
      check({tag, " cycle_cnt"}, cycle_cnt, 32'd0);
      check({tag, " retire_cnt"}, retire_cnt, 32'd0);
`endif
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cnt_chk("reset");
      op = 6'h08;
      vec("addi fetch0", 1'b0, 1'b0, FW);
      vec("addi fetch1", 1'b1, 1'b0, FH);
      dsel("addi", 13'h1fff, 13'b01_01_00_1_1_00000);
      vec("addi exec", 1'b0, 1'b0, EXQ);
      vec("addi wb", 1'b0, 1'b0, WB0);
      op = 6'h02;
      vec("j fetch", 1'b1, 1'b0, FH);
      vec("j dec", 1'b0, 1'b0, DEC);
      vec("j exec", 1'b0, 1'b0, JMP);
      op = 6'h23;
      vec("lw fetch", 1'b1, 1'b0, FH);
      dsel("lw", 13'h1fff, 13'b01_10_00_1_1_00000);
      vec("lw exec", 1'b0, 1'b0, EXQ);
      vec("lw mem0", 1'b0, 1'b0, MRD);
      vec("lw mem1", 1'b0, 1'b1, MRD);
      vec("lw wb", 1'b0, 1'b0, WB0);
      cnt_chk("three instr");
      op = 6'h2b;
      vec("sw fetch", 1'b1, 1'b0, FH);
      vec("sw dec", 1'b0, 1'b0, DEC);
      vec("sw exec", 1'b0, 1'b0, EXQ);
      repeat (3) vec("sw mem wait", 1'b0, 1'b0, MSW);
      vec("sw mem done", 1'b0, 1'b1, MSD);
      op = 6'h04;
      Z = 1'b1;
      vec("beq fetch", 1'b1, 1'b0, FH);
      dsel("beq", 13'b00_00_11_1_0_11111, 13'b00_00_00_0_0_00001);
      vec("beq taken", 1'b0, 1'b0, BRT);
      op = 6'h05;
      vec("bne fetch", 1'b1, 1'b0, FH);
      vec("bne dec", 1'b0, 1'b0, DEC);
      vec("bne not taken", 1'b0, 1'b0, BRN);
      Z = 1'b0;
      op = 6'h00;
      func = 6'h08;
      vec("jr fetch", 1'b1, 1'b0, FH);
      vec("jr dec", 1'b0, 1'b0, DEC);
      vec("jr exec", 1'b0, 1'b0, JRG);
      op = 6'h03;
      vec("jal fetch", 1'b1, 1'b0, FH);
      dsel("jal", 13'b11_11_00_0_0_00000, 13'b10_00_00_0_0_00000);
      vec("jal exec", 1'b0, 1'b0, EXQ);
      vec("jal wb", 1'b0, 1'b0, WBJ);
      op = 6'h00;
      func = 6'h09;
      vec("jalr fetch", 1'b1, 1'b0, FH);
      vec("jalr dec", 1'b0, 1'b0, DEC);
      vec("jalr exec", 1'b0, 1'b0, EXQ);
      vec("jalr wb", 1'b0, 1'b0, WBR);
      func = 6'h22;
      vec("sub fetch", 1'b1, 1'b0, FH);
      dsel("sub", 13'b11_11_11_1_0_11111, 13'b00_01_00_0_0_00001);
      vec("sub exec", 1'b0, 1'b0, EXQ);
      vec("sub wb", 1'b0, 1'b0, WB0);
      op = 6'h0f;
      vec("lui fetch", 1'b1, 1'b0, FH);
      dsel("lui", 13'h1fff, 13'b01_01_10_1_0_01000);
      vec("lui exec", 1'b0, 1'b0, EXQ);
      vec("lui wb", 1'b0, 1'b0, WB0);
      op = 6'h23;
      vec("lw-to fetch", 1'b1, 1'b0, FH);
      vec("lw-to dec", 1'b0, 1'b0, DEC);
      vec("lw-to exec", 1'b0, 1'b0, EXQ);
      repeat (14) vec("lw-to mem wait", 1'b0, 1'b0, MRD);
      vec("lw-to timeout", 1'b0, 1'b0, MTO);
      vec("lw-to back in fetch", 1'b0, 1'b0, FW);
      vec("lw-late fetch", 1'b1, 1'b0, FH);
      vec("lw-late dec", 1'b0, 1'b0, DEC);
      vec("lw-late exec", 1'b0, 1'b0, EXQ);
      repeat (14) vec("lw-late mem wait", 1'b0, 1'b0, MRD);
      vec("lw-late ready at limit", 1'b0, 1'b1, MRD);
      vec("lw-late wb", 1'b0, 1'b0, WB0);
      repeat (14) vec("fetch wait", 1'b0, 1'b0, FW);
      vec("fetch timeout", 1'b0, 1'b0, FTO);
      vec("fetch after timeout", 1'b0, 1'b0, FW);
      op = 6'h3f;
      vec("illegal fetch", 1'b1, 1'b0, FH);
      vec("illegal dec", 1'b0, 1'b0, ILL);
      op = 6'h2b;
      vec("sw-en fetch", 1'b1, 1'b0, FH);
      vec("sw-en dec", 1'b0, 1'b0, DEC);
      vec("sw-en exec", 1'b0, 1'b0, EXQ);
      vec("sw-en mem", 1'b0, 1'b0, MSW);
      enable = 1'b0;
      repeat (2) vec("sw-en frozen", 1'b0, 1'b0, MRD);
      vec("sw-en frozen ready", 1'b0, 1'b1, MRD);
      enable = 1'b1;
      vec("sw-en resume", 1'b0, 1'b1, MSD);
      cnt_chk("after freeze");
      op = 6'h08;
      vec("addi-rst fetch", 1'b1, 1'b0, FH);
      vec("addi-rst dec", 1'b0, 1'b0, DEC);
      vec("addi-rst exec", 1'b0, 1'b0, EXQ);
      reset_n = 1'b0;
      vec("addi-rst wb blocked", 1'b0, 1'b0, WBX);
      reset_n = 1'b1;
      cnt_chk("addi-rst");
      vec("addi-rst fetch after", 1'b0, 1'b0, FW);
      op = 6'h23;
      vec("lw-rst fetch", 1'b1, 1'b0, FH);
      vec("lw-rst dec", 1'b0, 1'b0, DEC);
      vec("lw-rst exec", 1'b0, 1'b0, EXQ);
      vec("lw-rst mem", 1'b0, 1'b0, MRD);
      reset_n = 1'b0;
      vec("lw-rst mem in reset", 1'b0, 1'b0, MRD);
      reset_n = 1'b1;
      cnt_chk("lw-rst");
      vec("lw-rst fetch after", 1'b0, 1'b0, FW);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
